aes_128_dec: RTL and testbench
==============================

AES_128_DEC -- requirements
Module: aes_128_dec

Interface
REQ-001 The block SHALL have these ports, in this order (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  ciphertext/key present
- in_ready  out  1  block can accept
- key  in  128  AES-128 cipher key (round-0 key)
- in  in  128  ciphertext block
- out_valid  out  1  plaintext present
- out_ready  in  1  consumer accepts plaintext
- out  out  128  plaintext block
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Byte order SHALL be FIPS-197: bit [127:120] is state byte 0, and state is column-major.
REQ-004 The block SHALL instantiate 16 combinational inv_sbox (8-bit in/out) and 4 combinational S-box byte lookups for the key schedule.

Function
REQ-005 The FSM SHALL have states IDLE, EXPAND, ROUND, FINAL and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on a clock edge with in_valid=1 and in_ready=1.
REQ-007 On a transfer, the block SHALL capture in and key, load the round-key register with key, clear the round counter to 1, and go to EXPAND.
REQ-008 EXPAND SHALL last exactly 10 cycles:
- each cycle advances the forward key schedule by one round, using rcon 01,02,04,08,10,20,40,80,1b,36 in sequence;
- on the 10th cycle the block holds rk10 and loads state with ciphertext ^ rk10;
- the FSM then goes to ROUND with the counter at 9.
REQ-009 ROUND SHALL last exactly 9 cycles, and each cycle SHALL:
- perform state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_{n-1});
- step the key register backwards (inverse key schedule) from rk_n to rk_{n-1};
- decrement the counter.
REQ-010 FINAL SHALL last 1 cycle:
- state <= InvSubBytes(InvShiftRows(state)) ^ rk0;
- the key register SHALL then equal the captured key;
- the FSM goes to DONE.
REQ-011 In DONE, out_valid SHALL be 1, and out SHALL equal state and be held stable while out_ready=0.
REQ-012 On out_valid=1 and out_ready=1, the FSM SHALL go to IDLE, and the next transfer SHALL be accepted no earlier than the following edge.
REQ-013 Latency SHALL be exactly 20 cycles from the accepting edge to the edge after which out_valid=1.
REQ-014 Key and ciphertext inputs SHALL be ignored while in_ready=0, and the captured values SHALL be immune to input changes after acceptance.
REQ-015 in_valid asserted during DONE SHALL NOT be accepted until IDLE, with no lost or duplicated blocks.
REQ-016 InvMixColumns SHALL use GF(2^8) multiplication by 09, 0b, 0d and 0e with polynomial 0x11b, via xtime chains; no multipliers.

Reset
REQ-017 Asserting rst SHALL immediately put the block in IDLE:
- in_ready=1, out_valid=0, out=0;
- counter=0, key and state registers cleared.
REQ-018 Reset mid-operation (any state) SHALL abort the block with no output produced, and the first edge after deassertion with in_valid=1 SHALL be accepted.

Configuration
REQ-019 Macro AES_128_DEC_KEY_CACHE_EN SHALL enable a round-key cache.
REQ-020 With AES_128_DEC_KEY_CACHE_EN defined, the block SHALL:
- store {cache_valid, cached key, cached rk10} at the end of EXPAND;
- on a transfer whose key equals the cached key with cache_valid=1, skip EXPAND: load rk10 and state = ciphertext ^ rk10 on the accepting edge and go to ROUND with the counter at 9;
- give a latency of 10 cycles on a hit and 20 on a miss;
- clear cache_valid on rst.
REQ-021 Without AES_128_DEC_KEY_CACHE_EN, no cache registers SHALL exist and latency SHALL always be 20.

Verification
REQ-022 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff, out_valid 20 cycles after accept.
REQ-023 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0 throughout, and one transfer on release.
REQ-025 Reset mid-run: assert rst at cycle 7 of EXPAND, then issue the C.1 vector again -> no spurious out_valid and a correct result 20 cycles later.
REQ-026 Cache (macro defined): issue C.1 twice back-to-back with the same key -> second latency 10; then issue B with a new key -> latency 20; without the macro, all latencies are 20.
REQ-027 Input isolation: change key/in to all-ones one cycle after acceptance -> C.1 result unchanged.

Source files
------------

// File: rtl/aes_128_dec.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then 9 inverse rounds and a final round.
// Optional round-key cache (rk10 reuse for a repeated key) enabled by AES_128_DEC_KEY_CACHE_EN.

module gf_inv8 (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq, acc;

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    always_comb begin
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        y = acc;
    end
endmodule

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] v;
    gf_inv8 u_inv (.a(a), .y(v));
    assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;
    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    gf_inv8 u_inv (.a(b), .y(y));
endmodule

module aes_128_dec (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);
    typedef enum logic [2:0] {IDLE, EXPAND, ROUND, FINAL, DONE} state_t;

    state_t       fsm, fsm_nxt;
    logic [127:0] st, rk;
    logic [3:0]   cnt, rc_idx;
    logic [7:0]   rcon;
    logic [31:0]  sb_in, sb_out, temp;
    logic [127:0] rk_fwd, rk_bwd, sr, sub, ark, round_out;
    logic         hit;
    logic [127:0] cache_rk10;

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] o;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[31-8*j -: 8];
            m9[j] = xt(xt(xt(a[j]))) ^ a[j];
            mb[j] = xt(xt(xt(a[j]))) ^ xt(a[j]) ^ a[j];
            md[j] = xt(xt(xt(a[j]))) ^ xt(xt(a[j])) ^ a[j];
            me[j] = xt(xt(xt(a[j]))) ^ xt(xt(a[j])) ^ xt(a[j]);
        end
        for (int j = 0; j < 4; j++)
            o[31-8*j -: 8] = me[j] ^ mb[(j+1)%4] ^ md[(j+2)%4] ^ m9[(j+3)%4];
        return o;
    endfunction

    // Key schedule: the four S-box lookups serve forward expansion and backward stepping
    assign rc_idx = (fsm == EXPAND) ? cnt : cnt + 4'd1;
    assign rcon   = rcon_of(rc_idx);
    assign sb_in  = (fsm == EXPAND) ? rk[31:0] : (rk[31:0] ^ rk[63:32]);

    for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
        aes_sbox u_sbox (.a(sb_in[31-8*g -: 8]), .y(sb_out[31-8*g -: 8]));
    end

    assign temp = {sb_out[23:0], sb_out[31:24]} ^ {rcon, 24'h0};

    assign rk_fwd[127:96] = rk[127:96] ^ temp;
    assign rk_fwd[95:64]  = rk[95:64] ^ rk_fwd[127:96];
    assign rk_fwd[63:32]  = rk[63:32] ^ rk_fwd[95:64];
    assign rk_fwd[31:0]   = rk[31:0] ^ rk_fwd[63:32];

    assign rk_bwd[127:96] = rk[127:96] ^ temp;
    assign rk_bwd[95:64]  = rk[95:64] ^ rk[127:96];
    assign rk_bwd[63:32]  = rk[63:32] ^ rk[95:64];
    assign rk_bwd[31:0]   = rk[31:0] ^ rk[63:32];

    // Round datapath; the round key added is always the one just stepped back to
    assign sr = inv_shift_rows(st);

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        inv_sbox u_isbox (.a(sr[127-8*g -: 8]), .y(sub[127-8*g -: 8]));
    end

    assign ark = sub ^ rk_bwd;

    for (genvar g = 0; g < 4; g++) begin : g_imc
        assign round_out[127-32*g -: 32] = inv_mix_col(ark[127-32*g -: 32]);
    end

`ifdef AES_128_DEC_KEY_CACHE_EN
    logic         cache_valid;
    logic [127:0] cache_key, cap_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk10  <= '0;
            cap_key     <= '0;
        end else begin
            if (fsm == IDLE && in_valid) cap_key <= key;
            if (fsm == EXPAND && cnt == 4'd10) begin
                cache_valid <= 1'b1;
                cache_key   <= cap_key;
                cache_rk10  <= rk_fwd;
            end
        end
    end

    assign hit = cache_valid && (key == cache_key);
`else
    assign hit        = 1'b0;
    assign cache_rk10 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = hit ? ROUND : EXPAND;
            end
            EXPAND:  if (cnt == 4'd10) fsm_nxt = ROUND;
            ROUND:   if (cnt == 4'd1) fsm_nxt = FINAL;
            FINAL:   fsm_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // During EXPAND the state register holds the captured ciphertext
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= '0;
            rk  <= '0;
            cnt <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    rk  <= hit ? cache_rk10 : key;
                    st  <= hit ? (in ^ cache_rk10) : in;
                    cnt <= hit ? 4'd9 : 4'd1;
                end
                EXPAND: begin
                    rk <= rk_fwd;
                    if (cnt == 4'd10) begin
                        st  <= st ^ rk_fwd;
                        cnt <= 4'd9;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    rk  <= rk_bwd;
                    st  <= round_out;
                    cnt <= cnt - 4'd1;
                end
                FINAL: begin
                    rk <= rk_bwd;
                    st <= ark;
                end
                default: ;
            endcase
        end
    end

    assign out = st;
endmodule

// File: tb/tb_aes_128_dec.sv
// Bench for aes_128_dec: FIPS-197 vectors, backpressure, mid-run reset, input isolation and random
// blocks checked against an array-based AES-128 decryption model (cache-aware via AES_128_DEC_KEY_CACHE_EN).

module tb_aes_128_dec;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_i;
    logic [127:0] ct_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox [256];
    logic [7:0] isbox [256];

`ifdef AES_128_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    bit           m_cvalid = 1'b0;
    logic [127:0] m_ckey = '0;

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    aes_128_dec dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key_i),
        .in(ct_i), .out_valid(out_valid), .out_ready(out_ready), .out(pt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] p = 8'h01;
        logic [7:0] q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox[p] = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
        end
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] ct);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, b0;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                b0 = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[b0];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = isbox[s[4*((c+4-rr)%4)+rr]] ^ w[16*r+4*c+rr];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int rr = 0; rr < 4; rr++)
                        s[4*c+rr] = gm(t[4*c+rr], 8'h0e) ^ gm(t[4*c+(rr+1)%4], 8'h0b)
                                  ^ gm(t[4*c+(rr+2)%4], 8'h0d) ^ gm(t[4*c+(rr+3)%4], 8'h09);
            end else begin
                s = t;
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Starts #1 after an edge with the DUT idle; optionally presents the next block during DONE.
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] exp, input int hold, input bit pre,
                             input logic [127:0] nk, input logic [127:0] nct);
        int lat;
        int exp_lat;
        exp_lat = (CACHE && m_cvalid && k == m_ckey) ? 10 : 20;
        if (CACHE && exp_lat == 20) begin
            m_cvalid = 1'b1;
            m_ckey   = k;
        end
        check({tag, "_in_ready"}, in_ready, 1'b1);
        key_i = k;
        ct_i = ct;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        key_i = '1;
        ct_i = '1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_out"}, pt, exp);
        if (pre) begin
            in_valid = 1'b1;
            key_i = nk;
            ct_i = nct;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_out"}, pt, exp);
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, out_valid, 1'b0);
        check({tag, "_rel_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] rk, rc, prev_k;
        build_tables();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        key_i = '0;
        ct_i = '0;
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", pt, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_block("c1", C1_K, C1_CT, C1_PT, 0, 1'b0, '0, '0);
        run_block("c1_again", C1_K, C1_CT, C1_PT, 0, 1'b0, '0, '0);
        rc = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block("b_bp", B_K, B_CT, B_PT, 5, 1'b1, B_K, rc);
        run_block("b_next", B_K, rc, ref_dec(B_K, rc), 0, 1'b0, '0, '0);

        // Abort during the 7th EXPAND cycle
        key_i = C1_K;
        ct_i = C1_CT;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out", pt, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_cvalid = 1'b0;
        run_block("c1_after_rst", C1_K, C1_CT, C1_PT, 1, 1'b0, '0, '0);

        prev_k = C1_K;
        for (int i = 0; i < 8; i++) begin
            rk = ($urandom_range(2) == 0) ? prev_k : {$urandom(), $urandom(), $urandom(), $urandom()};
            rc = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block($sformatf("rnd%0d", i), rk, rc, ref_dec(rk, rc), $urandom_range(3), 1'b0, '0, '0);
            prev_k = rk;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
